mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: MEM_STAGE

---
 rtl/mem_stage_pkg.sv | 74 +++++++
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage_dmem_if.sv | 76 +++++++
 rtl/mem_stage.sv | 79 +++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: pipeline latch layouts, opcodes and request FSM states.
// Latch widths are derived from the structs so producer and consumer stages cannot drift apart.
package mem_stage_pkg;

  localparam int DBITS_DEF    = 32;
  localparam int MAX_WAIT_DEF = 255;

  typedef enum logic [3:0] {
    NOP_I = 4'd0,
    ADD_I = 4'd1,
    SUB_I = 4'd2,
    LW_I  = 4'd3,
    SW_I  = 4'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [31:0]          inst;
    logic [31:0]          pc;
    op_t                  op;
    logic [31:0]          inst_count;
    logic [DBITS_DEF-1:0] aluout;
    logic [4:0]           rd;
    logic                 wr_reg;
    logic [3:0]           itype;
    logic                 wr_mem;
    logic [DBITS_DEF-1:0] wr_val;
    logic [3:0]           bus_canary;
  } agex_latch_t;

  typedef struct packed {
    logic [31:0]          inst;
    logic [31:0]          pc;
    op_t                  op;
    logic [31:0]          inst_count;
    logic [DBITS_DEF-1:0] memout;
    logic [4:0]           rd;
    logic                 wr_reg;
    logic [3:0]           itype;
    logic [3:0]           bus_canary;
  } mem_latch_t;

  typedef struct packed {
    logic       mem_stall;
    logic [4:0] rd;
    logic       wr_reg;
  } mem_to_agex_t;

  localparam int AGEX_LATCH_WIDTH  = $bits(agex_latch_t);
  localparam int MEM_LATCH_WIDTH   = $bits(mem_latch_t);
  localparam int MEM_TO_AGEX_WIDTH = $bits(mem_to_agex_t);

  function automatic mem_latch_t retire(input agex_latch_t a,
                                        input logic [DBITS_DEF-1:0] memout,
                                        input logic wr_reg);
    mem_latch_t m;
    m.inst       = a.inst;
    m.pc         = a.pc;
    m.op         = a.op;
    m.inst_count = a.inst_count;
    m.memout     = memout;
    m.rd         = a.rd;
    m.wr_reg     = wr_reg;
    m.itype      = a.itype;
    m.bus_canary = a.bus_canary;
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response channel between the memory stage (master) and memory (slave).
interface mem_stage_if #(parameter int DBITS = 32);
  logic             dmem_req_valid;
  logic             dmem_req_ready;
  logic             dmem_req_we;
  logic [DBITS-1:0] dmem_req_addr;
  logic [DBITS-1:0] dmem_req_wdata;
  logic             dmem_rsp_valid;
  logic [DBITS-1:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_if.sv
// Request/response sequencer: valid asserts in the issue cycle, fields are held until ready,
// then one response (or a timeout after MAX_WAIT wait cycles) completes the access.
module mem_stage_dmem_if
  import mem_stage_pkg::*;
#(
  parameter int DBITS    = DBITS_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] addr_i,
  input  logic [DBITS-1:0] wdata_i,
  mem_stage_if.master      dmem,
  output logic             rsp_done_o,
  output logic             timeout_o
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  dmem_state_t      state_q;
  logic [7:0]       cnt_q;
  logic             we_q;
  logic [DBITS-1:0] addr_q;
  logic [DBITS-1:0] wdata_q;
  logic             in_idle;

  assign in_idle = (state_q == ST_IDLE);

  // Fields come straight from the inputs in the issue cycle, from the held copy afterwards.
  assign dmem.dmem_req_valid = reset && ((in_idle && start_i) || (state_q == ST_REQ));
  assign dmem.dmem_req_we    = in_idle ? we_i    : we_q;
  assign dmem.dmem_req_addr  = in_idle ? addr_i  : addr_q;
  assign dmem.dmem_req_wdata = in_idle ? wdata_i : wdata_q;

  assign rsp_done_o = (state_q == ST_WAIT) && dmem.dmem_rsp_valid;
  assign timeout_o  = (state_q == ST_WAIT) && !dmem.dmem_rsp_valid && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= '0;
            state_q <= dmem.dmem_req_ready ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem.dmem_req_ready) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem.dmem_rsp_valid || (cnt_q == LAST_CNT)) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU ops retire in 1 cycle; loads/stores stall upstream and insert
// bubbles until the response (best case 2 cycles); misaligned or timed-out accesses retire as bubbles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DBITS    = DBITS_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AGEX_LATCH_WIDTH-1:0]  from_AGEX_latch,
  mem_stage_if.master                  dmem,
  output logic [MEM_LATCH_WIDTH-1:0]   MEM_latch_out,
  output logic [MEM_TO_AGEX_WIDTH-1:0] from_MEM_to_AGEX,
  output logic                         err_misaligned,
  output logic                         err_timeout
);

  agex_latch_t  agex;
  mem_latch_t   latch_d, latch_q;
  mem_to_agex_t fwd;
  logic         bubble, mem_op, misaligned, start, rsp_done, timeout;
  logic         err_mis_q, err_to_q;

  assign agex       = agex_latch_t'(from_AGEX_latch);
  assign bubble     = (agex.inst == '0);
  assign mem_op     = !bubble && ((agex.op == LW_I) || agex.wr_mem);
  assign misaligned = mem_op && (agex.aluout[1:0] != 2'b00);
  assign start      = mem_op && !misaligned;

  mem_stage_dmem_if #(
    .DBITS    (DBITS),
    .MAX_WAIT (MAX_WAIT)
  ) u_dmem (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .we_i       (agex.wr_mem),
    .addr_i     (agex.aluout),
    .wdata_i    (agex.wr_val),
    .dmem       (dmem),
    .rsp_done_o (rsp_done),
    .timeout_o  (timeout)
  );

  // Upstream holds the instruction while stalled, so its fields are still valid at response time.
  always_comb begin
    latch_d = '0;
    if (rsp_done) begin
      latch_d = retire(agex, agex.wr_mem ? agex.aluout : dmem.dmem_rsp_rdata,
                       agex.wr_reg && !agex.wr_mem);
    end else if (!bubble && !mem_op) begin
      latch_d = retire(agex, agex.aluout, agex.wr_reg);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_q   <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      err_mis_q <= err_mis_q | misaligned;
      err_to_q  <= err_to_q | timeout;
    end
  end

  // Stall also releases on timeout so the abandoned access is not reissued.
  assign fwd.mem_stall = reset && start && !rsp_done && !timeout;
  assign fwd.rd        = agex.rd;
  assign fwd.wr_reg    = !bubble && agex.wr_reg && !agex.wr_mem;

  assign MEM_latch_out    = latch_q;
  assign from_MEM_to_AGEX = fwd;
  assign err_misaligned   = err_mis_q;
  assign err_timeout      = err_to_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench acts as both upstream stage and memory; expectations follow from the chosen delays.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;
  agex_latch_t agex;
  logic [MEM_LATCH_WIDTH-1:0]   mem_bits;
  logic [MEM_TO_AGEX_WIDTH-1:0] fwd_bits;
  mem_to_agex_t fwd;
  logic err_mis, err_to;
  int   n_vec = 0;
  int   n_err = 0;
  bit   exp_mis = 1'b0;
  bit   exp_to  = 1'b0;

  mem_stage_if #(.DBITS(32)) dmem_bus ();

  mem_stage #(.DBITS(32), .MAX_WAIT(MW)) dut (
    .clk              (clk),
    .reset            (reset),
    .from_AGEX_latch  (agex),
    .dmem             (dmem_bus),
    .MEM_latch_out    (mem_bits),
    .from_MEM_to_AGEX (fwd_bits),
    .err_misaligned   (err_mis),
    .err_timeout      (err_to)
  );

  assign fwd = mem_to_agex_t'(fwd_bits);

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic mem_latch_t exp_latch(input agex_latch_t a, input logic [31:0] rdata);
    mem_latch_t m;
    m.inst       = a.inst;
    m.pc         = a.pc;
    m.op         = a.op;
    m.inst_count = a.inst_count;
    m.rd         = a.rd;
    m.itype      = a.itype;
    m.bus_canary = a.bus_canary;
    m.memout     = (a.op == LW_I && !a.wr_mem) ? rdata : a.aluout;
    m.wr_reg     = a.wr_mem ? 1'b0 : a.wr_reg;
    return m;
  endfunction

  function automatic agex_latch_t mk(input op_t op, input logic [31:0] addr, input logic [31:0] val);
    agex_latch_t a;
    a.inst       = $urandom() | 32'h1;
    a.pc         = $urandom();
    a.op         = op;
    a.inst_count = $urandom();
    a.aluout     = addr;
    a.rd         = 5'($urandom());
    a.wr_reg     = (op != SW_I);
    a.itype      = 4'($urandom());
    a.wr_mem     = (op == SW_I);
    a.wr_val     = val;
    a.bus_canary = 4'($urandom());
    return a;
  endfunction

  task automatic chk_comb(input string tag, input bit vld, input agex_latch_t a, input bit stall);
    chk({tag, ".req_vld"}, 256'(dmem_bus.dmem_req_valid), 256'(vld));
    if (vld) begin
      chk({tag, ".we"},    256'(dmem_bus.dmem_req_we),    256'(a.wr_mem));
      chk({tag, ".addr"},  256'(dmem_bus.dmem_req_addr),  256'(a.aluout));
      chk({tag, ".wdata"}, 256'(dmem_bus.dmem_req_wdata), 256'(a.wr_val));
    end
    chk({tag, ".stall"}, 256'(fwd.mem_stall), 256'(stall));
  endtask

  // Present one instruction; d_r = not-ready cycles, d_s = silent wait cycles before the response.
  task automatic run_instr(input string tag, input agex_latch_t a, input int d_r, input int d_s,
                           input logic [31:0] rdata);
    bit bub, mem, mis, to;
    int nw;
    mem_latch_t exp;
    bub  = (a.inst == 0);
    mem  = !bub && (a.op == LW_I || a.wr_mem);
    mis  = mem && (a.aluout[1:0] != 2'b00);
    agex = a;
    if (!mem || mis) begin
      dmem_bus.dmem_req_ready = 1'($urandom());
      dmem_bus.dmem_rsp_valid = 1'($urandom());
      dmem_bus.dmem_rsp_rdata = $urandom();
      @(negedge clk);
      chk_comb(tag, 1'b0, a, 1'b0);
      @(posedge clk); #1;
      if (mis) exp_mis = 1'b1;
      exp = (bub || mis) ? mem_latch_t'('0) : exp_latch(a, 32'h0);
      chk({tag, ".latch"}, 256'(mem_bits), 256'(exp));
    end else begin
      to = (d_s >= MW);
      for (int c = 0; c <= d_r; c++) begin
        dmem_bus.dmem_req_ready = (c == d_r);
        dmem_bus.dmem_rsp_valid = 1'($urandom());
        dmem_bus.dmem_rsp_rdata = $urandom();
        @(negedge clk);
        chk_comb({tag, ".req"}, 1'b1, a, 1'b1);
        @(posedge clk); #1;
        chk({tag, ".req_bubble"}, 256'(mem_bits), 256'(0));
      end
      nw = to ? MW : d_s + 1;
      for (int c = 0; c < nw; c++) begin
        dmem_bus.dmem_req_ready = 1'($urandom());
        dmem_bus.dmem_rsp_valid = (c == nw - 1) && !to;
        dmem_bus.dmem_rsp_rdata = (c == nw - 1) ? rdata : $urandom();
        @(negedge clk);
        chk_comb({tag, ".wait"}, 1'b0, a, c != nw - 1);
        @(posedge clk); #1;
        if (c == nw - 1 && to) exp_to = 1'b1;
        exp = (c == nw - 1 && !to) ? exp_latch(a, rdata) : mem_latch_t'('0);
        chk({tag, ".wait_latch"}, 256'(mem_bits), 256'(exp));
      end
    end
    dmem_bus.dmem_rsp_valid = 1'b0;
    chk({tag, ".err_mis"}, 256'(err_mis), 256'(exp_mis));
    chk({tag, ".err_to"},  256'(err_to),  256'(exp_to));
  endtask

  initial begin
    agex_latch_t a;
    int k;
    reset = 1'b0;
    dmem_bus.dmem_req_ready = 1'b1;
    dmem_bus.dmem_rsp_valid = 1'b1;
    dmem_bus.dmem_rsp_rdata = 32'h0;
    agex = mk(LW_I, 32'h40, 32'h0);
    #12;
    chk("rst.latch",   256'(mem_bits), 256'(0));
    chk("rst.req_vld", 256'(dmem_bus.dmem_req_valid), 256'(0));
    chk("rst.stall",   256'(fwd.mem_stall), 256'(0));
    chk("rst.err_mis", 256'(err_mis), 256'(0));
    chk("rst.err_to",  256'(err_to), 256'(0));
    agex = '0;
    dmem_bus.dmem_rsp_valid = 1'b0;
    reset = 1'b1;

    run_instr("add5", mk(ADD_I, 32'h5, 32'h0), 0, 0, 32'h0);
    run_instr("lw100", mk(LW_I, 32'h100, 32'h0), 0, 3, 32'hDEAD_BEEF);
    run_instr("sw104", mk(SW_I, 32'h104, 32'h1234), 2, 0, 32'h0);
    run_instr("bubble", '0, 0, 0, 32'h0);
    run_instr("lw102", mk(LW_I, 32'h102, 32'h0), 0, 0, 32'h0);
    run_instr("lw_to", mk(LW_I, 32'h200, 32'h0), 1, MW, 32'h0);

    // Reset during WAIT, then a stray response after release.
    agex = mk(LW_I, 32'h300, 32'h0);
    dmem_bus.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_req_ready = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    exp_mis = 1'b0;
    exp_to  = 1'b0;
    chk("mid_rst.latch",   256'(mem_bits), 256'(0));
    chk("mid_rst.req_vld", 256'(dmem_bus.dmem_req_valid), 256'(0));
    chk("mid_rst.stall",   256'(fwd.mem_stall), 256'(0));
    chk("mid_rst.err_mis", 256'(err_mis), 256'(0));
    chk("mid_rst.err_to",  256'(err_to), 256'(0));
    @(posedge clk); #1;
    agex = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    dmem_bus.dmem_rsp_valid = 1'b1;
    dmem_bus.dmem_rsp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_rsp.req_vld", 256'(dmem_bus.dmem_req_valid), 256'(0));
    @(posedge clk); #1;
    chk("late_rsp.latch", 256'(mem_bits), 256'(0));
    dmem_bus.dmem_rsp_valid = 1'b0;
    run_instr("add_post_rst", mk(ADD_I, 32'hCAFE_0001, 32'h0), 0, 0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       a = '0;
        1, 2, 3: a = mk((k == 1) ? SUB_I : ADD_I, $urandom(), $urandom());
        4, 5:    a = mk(LW_I, $urandom() & 32'hFFFF_FFFC, $urandom());
        6, 7:    a = mk(SW_I, $urandom() & 32'hFFFF_FFFC, $urandom());
        8:       a = mk((i % 2 == 0) ? LW_I : SW_I, ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)), $urandom());
        default: a = mk(LW_I, $urandom() & 32'hFFFF_FFFC, $urandom());
      endcase
      if (k == 0) a.pc = $urandom();
      run_instr("rnd", a, $urandom_range(0, 3),
                (k == 9) ? $urandom_range(MW, MW + 1) : $urandom_range(0, 3), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
